// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - 4-bit operation codes (combined with the cin modifier bit)
//   - FSM state type for the single-cycle / multiply sequencer
//   - bit positions of Z, N, C, V inside the 4-bit flags bus
//   - op_legal(): which {op_code, cin} pairs are defined operations
package alu_seq_pkg;

  localparam logic [3:0] OP_PASS = 4'b0000;  // cin=0: Aop, cin=1: Aop+1
  localparam logic [3:0] OP_ADD  = 4'b0001;  // Aop+B+cin
  localparam logic [3:0] OP_SUB  = 4'b0010;  // Aop+~B+1, cin ignored
  localparam logic [3:0] OP_DEC  = 4'b0011;  // cin=0: Aop-1, cin=1: Aop
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_ZERO = 4'b1000;
  localparam logic [3:0] OP_SH   = 4'b1001;  // cin=0: <<, cin=1: logical >>
  localparam logic [3:0] OP_SRA  = 4'b1010;  // cin=1 only
  localparam logic [3:0] OP_MUL  = 4'b1011;  // cin=0 only

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Returns 1 when {op, cin} selects a defined operation.
  function automatic logic op_legal(input logic [3:0] op, input logic cin);
    logic legal_s;
    case (op)
      OP_PASS, OP_ADD, OP_SUB, OP_DEC, OP_SH:                legal_s = 1'b1;
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ZERO, OP_MUL:        legal_s = ~cin;
      OP_SRA:                                                legal_s = cin;
      default:                                               legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-and-add multiplier, one iteration per
// enabled clock, WIDTH iterations per product.
//   clk, rst_n  clock and asynchronous active-low reset
//   en          iteration enable; 0 freezes every register
//   start       load a/b and clear the partial product
//   a, b        multiplicand / multiplier (sampled with start)
//   done        the iteration running this cycle is the last one
//   product     full 2*WIDTH product including this cycle's iteration
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [2*WIDTH-1:0] prod_next_s;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;
  logic               done_s;

  // Partial product after this cycle's iteration.
  always_comb begin
    if (mplier_r[0]) begin
      prod_next_s = prod_r + mcand_r;
    end else begin
      prod_next_s = prod_r;
    end
  end

  assign done_s  = busy_r && (cnt_r == LAST_CNT);
  assign done    = done_s;
  assign product = prod_next_s;

  // Operand load on start, then one shift-and-add step per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      prod_r   <= '0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
    end else if (en) begin
      if (start) begin
        mcand_r  <= {{WIDTH{1'b0}}, a};
        mplier_r <= b;
        prod_r   <= '0;
        cnt_r    <= '0;
        busy_r   <= 1'b1;
      end else if (busy_r) begin
        prod_r   <= prod_next_s;
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
        if (done_s) begin
          cnt_r  <= '0;
          busy_r <= 1'b0;
        end else begin
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with shifts, an iterative multiply,
// status flags and an accumulator operand path.
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  global enable; 0 freezes all state
//   in_valid/in_ready   request handshake from decode
//   op_code, cin        operation select and modifier
//   use_acc             take operand A from the accumulator
//   A, B                operands
//   out_valid/out_ready result handshake to write-back
//   Y, flags, err       registered result, {Z,N,C,V}, illegal-op flag
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_code,
  input  logic             cin,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_e             state_r;
  logic [WIDTH-1:0]   y_r;
  logic [3:0]         flags_r;
  logic               err_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   acc_r;

  logic               in_ready_s;
  logic               accept_s;
  logic               legal_s;
  logic               is_mul_s;
  logic               mul_start_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic [WIDTH-1:0]   aop_s;
  logic [SHW-1:0]     shamt_s;

  logic [WIDTH-1:0]   add_x_s;
  logic               add_c_s;
  logic [WIDTH:0]     add_sum_s;
  logic               add_v_s;
  logic [WIDTH:0]     shl_ext_s;
  logic [WIDTH:0]     shr_ext_s;
  logic [WIDTH:0]     sra_ext_s;

  logic [WIDTH-1:0]   alu_y_s;
  logic               alu_c_s;
  logic               alu_v_s;

  logic               wr_en_s;
  logic [WIDTH-1:0]   wr_y_s;
  logic               wr_c_s;
  logic               wr_v_s;
  logic               wr_err_s;
  logic [3:0]         wr_flags_s;

  assign in_ready_s  = (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s    = en && in_valid && in_ready_s;
  assign legal_s     = op_legal(op_code, cin);
  assign is_mul_s    = (op_code == OP_MUL) && !cin;
  assign mul_start_s = accept_s && is_mul_s;
  assign aop_s       = use_acc ? acc_r : A;
  assign shamt_s     = B[SHW-1:0];

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .start   (mul_start_s),
    .a       (aop_s),
    .b       (B),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // Second adder operand: pass/inc add 0, dec adds all-ones (so cin=1
  // gives Aop with C=1, i.e. "decrement by zero, no borrow").
  always_comb begin
    add_c_s = cin;
    case (op_code)
      OP_ADD:  add_x_s = B;
      OP_SUB:  begin
        add_x_s = ~B;
        add_c_s = 1'b1;
      end
      OP_DEC:  add_x_s = '1;
      default: add_x_s = '0;
    endcase
  end

  assign add_sum_s = {1'b0, aop_s} + {1'b0, add_x_s} + {{WIDTH{1'b0}}, add_c_s};
  assign add_v_s   = (aop_s[WIDTH-1] == add_x_s[WIDTH-1]) &&
                     (add_sum_s[WIDTH-1] != aop_s[WIDTH-1]);

  // One guard bit beyond the operand catches the last bit shifted out;
  // with a zero shift amount the guard stays 0.
  assign shl_ext_s = {1'b0, aop_s} << shamt_s;
  assign shr_ext_s = {aop_s, 1'b0} >> shamt_s;
  assign sra_ext_s = $signed({aop_s, 1'b0}) >>> shamt_s;

  // Single-cycle datapath result and carry/overflow.
  always_comb begin
    alu_y_s = '0;
    alu_c_s = 1'b0;
    alu_v_s = 1'b0;
    case (op_code)
      OP_PASS, OP_ADD, OP_SUB, OP_DEC: begin
        alu_y_s = add_sum_s[WIDTH-1:0];
        alu_c_s = add_sum_s[WIDTH];
        alu_v_s = add_v_s;
      end
      OP_AND:  alu_y_s = aop_s & B;
      OP_OR:   alu_y_s = aop_s | B;
      OP_XOR:  alu_y_s = aop_s ^ B;
      OP_NOT:  alu_y_s = ~aop_s;
      OP_ZERO: alu_y_s = '0;
      OP_SH: begin
        if (cin) begin
          alu_y_s = shr_ext_s[WIDTH:1];
          alu_c_s = shr_ext_s[0];
        end else begin
          alu_y_s = shl_ext_s[WIDTH-1:0];
          alu_c_s = shl_ext_s[WIDTH];
        end
      end
      OP_SRA: begin
        alu_y_s = sra_ext_s[WIDTH:1];
        alu_c_s = sra_ext_s[0];
      end
      default: alu_y_s = '0;
    endcase
  end

  // Pick the value to write: multiplier completion, illegal op or ALU.
  always_comb begin
    wr_y_s   = '0;
    wr_c_s   = 1'b0;
    wr_v_s   = 1'b0;
    wr_err_s = 1'b0;
    if (state_r == MUL) begin
      wr_y_s = mul_prod_s[WIDTH-1:0];
      wr_c_s = |mul_prod_s[2*WIDTH-1:WIDTH];
    end else if (!legal_s) begin
      wr_err_s = 1'b1;
    end else begin
      wr_y_s = alu_y_s;
      wr_c_s = alu_c_s;
      wr_v_s = alu_v_s;
    end
  end

  // Flags of the value being written; an illegal op reports all-zero flags.
  always_comb begin
    wr_flags_s = 4'b0000;
    if (wr_err_s) begin
      wr_flags_s = 4'b0000;
    end else begin
      wr_flags_s[FLAG_Z] = (wr_y_s == '0);
      wr_flags_s[FLAG_N] = wr_y_s[WIDTH-1];
      wr_flags_s[FLAG_C] = wr_c_s;
      wr_flags_s[FLAG_V] = wr_v_s;
    end
  end

  assign wr_en_s = (accept_s && !is_mul_s) || ((state_r == MUL) && mul_done_s);

  // Sequencer, output register and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      y_r         <= '0;
      flags_r     <= 4'b0000;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      acc_r       <= '0;
    end else if (en) begin
      if (wr_en_s) begin
        y_r         <= wr_y_s;
        flags_r     <= wr_flags_s;
        err_r       <= wr_err_s;
        acc_r       <= wr_y_s;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (mul_start_s) begin
            state_r <= MUL;
          end
        end
        MUL: begin
          if (mul_done_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign Y         = y_r;
  assign flags     = flags_r;
  assign err       = err_r;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op_code = 4'h0;
  logic       cin = 1'b0;
  logic       use_acc = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Y;
  logic [3:0] flags;
  logic       err;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .cin(cin), .use_acc(use_acc), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .flags(flags), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic [3:0] flags;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] model_acc = 8'h00;
  bit         rand_mode = 1'b0;
  logic       want_en = 1'b1;
  logic       want_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation table.
  function automatic exp_t model(input logic [3:0] op, input logic c,
                                 input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb, ci, r, sr, sh;
    logic cf, vf, bad;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); ci = c;
    sh = ub % 8; r = 0; sr = 0; cf = 1'b0; vf = 1'b0; bad = 1'b0;
    case ({op, c})
      5'b0000_0: r = ua;
      5'b0000_1: begin r = ua + 1; sr = sa + 1; cf = (r > 255); vf = (sr > 127); end
      5'b0001_0, 5'b0001_1: begin
        r = ua + ub + ci; sr = sa + sb + ci;
        cf = (r > 255); vf = (sr > 127) || (sr < -128);
      end
      5'b0010_0, 5'b0010_1: begin
        r = ua - ub; sr = sa - sb;
        cf = (ua >= ub); vf = (sr > 127) || (sr < -128);
      end
      5'b0011_0: begin r = ua - 1; sr = sa - 1; cf = (ua >= 1); vf = (sr < -128); end
      5'b0011_1: begin r = ua; cf = 1'b1; end
      5'b0100_0: r = ua & ub;
      5'b0101_0: r = ua | ub;
      5'b0110_0: r = ua ^ ub;
      5'b0111_0: r = ~ua;
      5'b1000_0: r = 0;
      5'b1001_0: begin r = ua << sh; cf = (sh == 0) ? 1'b0 : a[8 - sh]; end
      5'b1001_1: begin r = ua >> sh; cf = (sh == 0) ? 1'b0 : a[sh - 1]; end
      5'b1010_1: begin r = sa >>> sh; cf = (sh == 0) ? 1'b0 : a[sh - 1]; end
      5'b1011_0: begin r = ua * ub; cf = (r > 255); end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      e.y = 8'h00; e.flags = 4'b0000; e.err = 1'b1;
    end else begin
      e.y = r[7:0];
      e.flags = {(r[7:0] == 8'h00), r[7], cf, vf};
      e.err = 1'b0;
    end
    return e;
  endfunction

  // en / out_ready driver: random in rand_mode, otherwise follows want_*.
  initial begin
    en = 1'b1;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rand_mode) begin
        out_ready = ($urandom_range(0, 3) != 0);
        en = ($urandom_range(0, 9) != 0);
      end else begin
        out_ready = want_ready;
        en = want_en;
      end
    end
  end

  // Monitor: every completed output transfer is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got Y=0x%0h with no result expected", Y);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_y", 32'(Y), 32'(mon_e.y));
        check("sb_flags", 32'(flags), 32'(mon_e.flags));
        check("sb_err", 32'(err), 32'(mon_e.err));
      end
    end
  end

  // Present a request (called just after a rising edge); returns after
  // the accepting edge. waits = cycles the request was held off.
  task automatic issue(input logic [3:0] op, input logic c, input logic ua,
                       input logic [7:0] a, input logic [7:0] b, output int waits);
    exp_t e;
    bit ok;
    op_code = op; cin = c; use_acc = ua; A = a; B = b; in_valid = 1'b1;
    waits = 0;
    ok = 1'b0;
    while (!ok && waits < 200) begin
      @(negedge clk);
      if (in_ready && en) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    end else begin
      e = model(op, c, ua ? model_acc : a, b);
      exp_q.push_back(e);
      model_acc = e.y;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count negedges until out_valid; note whether in_ready rose meanwhile.
  task automatic wait_valid(output int lat, output bit rdy_seen);
    bit got;
    lat = 0;
    rdy_seen = 1'b0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else begin
        if (in_ready) rdy_seen = 1'b1;
        lat++;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL valid_timeout: out_valid stayed 0, expected 1 within 100 cycles");
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  w;
    int  lat;
    int  seen;
    bit  rdy;

    // Reset
    #1 rst_n = 1'b0;
    #2;
    check("rst_y", 32'(Y), 32'h00);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    next_cycle();

    // Add with signed overflow, latency 1
    issue(4'b0001, 1'b0, 1'b0, 8'h7F, 8'h01, w);
    wait_valid(lat, rdy);
    check("add_latency", 32'(lat), 32'd0);
    check("add_y", 32'(Y), 32'h80);
    check("add_flags", 32'(flags), 32'b0101);
    next_cycle();

    // Subtract with borrow
    issue(4'b0010, 1'b0, 1'b0, 8'h00, 8'h01, w);
    wait_valid(lat, rdy);
    check("sub_y", 32'(Y), 32'hFF);
    check("sub_flags", 32'(flags), 32'b0100);
    next_cycle();

    // Backpressure: result held, no accept, then same-cycle accept
    want_ready = 1'b0;
    issue(4'b0100, 1'b0, 1'b0, 8'hF0, 8'h3C, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_y_hold", 32'(Y), 32'h30);
      check("bp_valid_hold", 32'(out_valid), 32'h1);
      check("bp_in_ready", 32'(in_ready), 32'h0);
    end
    next_cycle();
    want_ready = 1'b1;
    issue(4'b0110, 1'b0, 1'b0, 8'h0F, 8'hFF, w);
    check("bp_same_cycle_accept", 32'(w), 32'd0);
    wait_valid(lat, rdy);
    check("xor_y", 32'(Y), 32'hF0);
    next_cycle();

    // Multiply 13*11
    issue(4'b1011, 1'b0, 1'b0, 8'd13, 8'd11, w);
    wait_valid(lat, rdy);
    check("mul_latency", 32'(lat), 32'd8);
    check("mul_in_ready_low", 32'(rdy), 32'd0);
    check("mul_y", 32'(Y), 32'h8F);
    check("mul_flags", 32'(flags), 32'b0100);
    next_cycle();

    // Multiply overflowing into the upper half
    issue(4'b1011, 1'b0, 1'b0, 8'h20, 8'h10, w);
    wait_valid(lat, rdy);
    check("mul_ovf_y", 32'(Y), 32'h00);
    check("mul_ovf_flags", 32'(flags), 32'b1010);
    next_cycle();

    // Increment, accumulator shift, arithmetic right shift
    issue(4'b0000, 1'b1, 1'b0, 8'h05, 8'h00, w);
    wait_valid(lat, rdy);
    check("inc_y", 32'(Y), 32'h06);
    next_cycle();
    issue(4'b1001, 1'b0, 1'b1, 8'hAA, 8'h02, w);
    wait_valid(lat, rdy);
    check("acc_shl_y", 32'(Y), 32'd24);
    next_cycle();
    issue(4'b1010, 1'b1, 1'b0, 8'h80, 8'h03, w);
    wait_valid(lat, rdy);
    check("sra_y", 32'(Y), 32'hF0);
    check("sra_flags", 32'(flags), 32'b0100);
    next_cycle();

    // Illegal code clears the accumulator
    issue(4'b1111, 1'b1, 1'b0, 8'h33, 8'h44, w);
    wait_valid(lat, rdy);
    check("illegal_y", 32'(Y), 32'h00);
    check("illegal_err", 32'(err), 32'h1);
    check("illegal_flags", 32'(flags), 32'h0);
    next_cycle();
    issue(4'b0000, 1'b0, 1'b1, 8'h55, 8'h00, w);
    wait_valid(lat, rdy);
    check("acc_after_err", 32'(Y), 32'h00);
    check("acc_after_err_flags", 32'(flags), 32'b1000);
    next_cycle();

    // en=0 for 4 cycles during a multiply
    issue(4'b1011, 1'b0, 1'b0, 8'd13, 8'd11, w);
    want_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 want_en = 1'b1;
    wait_valid(lat, rdy);
    check("mul_stall_latency", 32'(lat + 4), 32'd12);
    check("mul_stall_y", 32'(Y), 32'h8F);
    next_cycle();

    // Randomised traffic with random backpressure and enable
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
      if ($urandom_range(0, 3) == 0) next_cycle();
    end
    rand_mode = 1'b0;
    want_en = 1'b1;
    want_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    next_cycle();

    // Asynchronous reset while a result is held
    want_ready = 1'b0;
    issue(4'b0001, 1'b0, 1'b0, 8'h7F, 8'h01, w);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_y", 32'(Y), 32'h00);
    check("async_rst_flags", 32'(flags), 32'h0);
    check("async_rst_valid", 32'(out_valid), 32'h0);
    exp_q.delete();
    model_acc = 8'h00;
    next_cycle();
    rst_n = 1'b1;
    want_ready = 1'b1;
    @(negedge clk);
    check("async_rst_in_ready", 32'(in_ready), 32'h1);
    next_cycle();

    // Reset in the middle of a multiply: nothing emerges
    issue(4'b1011, 1'b0, 1'b0, 8'd13, 8'd11, w);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    exp_q.delete();
    model_acc = 8'h00;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mul_abort_no_result", 32'(seen), 32'd0);
    check("mul_abort_in_ready", 32'(in_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 4-bit registered ALU.
- Same {op_code, cin} operation encoding, generalised to WIDTH bits, plus:
  - shifts
  - a multi-cycle shift-and-add multiply
  - status flags
  - an accumulator operand path
- Sits between the CPU decode stage (upstream valid/ready) and the register write-back (downstream valid/ready).

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; 0 freezes all state, including the FSM, multiply counter and output register.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request this cycle.
- op_code  input  4  operation select.
- cin  input  1  operation modifier bit.
- use_acc  input  1  1: operand A is taken from acc instead of port A.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  Y and flags are valid.
- out_ready  input  1  downstream accepts result.
- Y  output  WIDTH  result.
- flags  output  4  {Z,N,C,V}.
- err  output  1  illegal opcode for the current result.

Behaviour:
- Reset (rst_n=0, async): Y=0, flags=0, err=0, out_valid=0, acc=0, FSM=IDLE, mul counter=0. in_ready is 1 once rst_n is released.
- Accept: a request is accepted when en && in_valid && in_ready. Define in_ready = (state==IDLE) && (!out_valid || out_ready).
- Operand selection: Aop = use_acc ? acc : A, sampled at accept.
- Ops, keyed by {op_code,cin}:
  - 0000_0: Aop
  - 0000_1: Aop+1
  - 0001_0: Aop+B
  - 0001_1: Aop+B+1
  - 0010_x: Aop+~B+1
  - 0011_0: Aop-1
  - 0011_1: Aop
  - 0100_0: Aop&B
  - 0101_0: Aop|B
  - 0110_0: Aop^B
  - 0111_0: ~Aop
  - 1000_0: 0
  - 1001_0: Aop<<B[SHW-1:0]
  - 1001_1: logical >>
  - 1010_1: arithmetic >>
  - 1011_0: MUL, low WIDTH bits of Aop*B.
  - Any other code: Y=0, err=1, flags=0.
- Single-cycle ops:
  - The result is registered on the accept edge; out_valid=1 the next cycle (latency 1).
  - Back-to-back accepts are allowed when out_ready=1, giving full throughput.
- MUL:
  - FSM IDLE -> MUL -> IDLE. On accept, load multiplicand/multiplier and clear the partial product.
  - Perform WIDTH iterations, one per en-cycle. Move to IDLE and set out_valid on the final iteration, so latency is WIDTH cycles.
  - in_ready=0 while in MUL. Flags: Z, N from the result; C=1 if the upper WIDTH product bits are nonzero; V=0.
- Flags:
  - Z = (Y==0); N = Y[WIDTH-1].
  - Add/inc: C = carry out of bit WIDTH-1.
  - Sub/dec: C = 1 means no borrow.
  - V: signed overflow for add/sub/inc/dec.
  - Logic/pass/zero: C=0, V=0.
  - Shifts: C = last bit shifted out (0 if amount is 0); V=0.
- Output hold: while out_valid && !out_ready, Y, flags and err are held stable and no new request is accepted. out_valid clears on out_ready if there is no new result that cycle.
- Accumulator: acc <= Y each time a result is written, including MUL and err results (err writes acc=0).
- Enable: en=0 inhibits accept, FSM advance and all register updates. in_ready is still driven combinationally; handshakes are ignored while en=0.
- Reset mid-MUL aborts the operation; no result is emitted.

Decomposition:
- Package alu_seq_pkg holds:
  - localparam op/cin encodings (OP_PASS, OP_ADD, OP_SUB, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ZERO, OP_SH, OP_SRA, OP_MUL).
  - FSM state typedef {IDLE, MUL}.
  - Flag bit indices.
- One sub-module: alu_seq_mul, the iterative shift-and-add multiplier with start/done and a WIDTH parameter. Everything else stays in alu_seq.

Test Plan:
- Reset, WIDTH=8: assert rst_n=0 mid-stream -> Y=0x00, flags=0, out_valid=0 immediately (async). After release, in_ready=1.
- Add: A=0x7F, B=0x01, op 0001_0 -> next cycle Y=0x80, flags {Z,N,C,V}=0101. Sub: A=0x00, B=0x01, op 0010_0 -> Y=0xFF, flags 0100.
- Backpressure: issue AND 0xF0&0x3C with out_ready=0 for 3 cycles -> Y=0x30 held, in_ready=0. Raise out_ready -> result consumed; the next request is accepted the same cycle.
- MUL: A=13, B=11 -> in_ready=0 for 8 cycles, then Y=0x8F, C=0. A=0x20, B=0x10 -> Y=0x00, Z=1, C=1.
- Accumulator/shift: op 0000_1 with A=5 -> Y=6. Then use_acc=1, op 1001_0, B=2 -> Y=24. Then op 1010_1 on A=0x80, B=3 -> Y=0xF0.
- Illegal code 1111_1 -> Y=0, err=1, acc=0. en=0 during MUL for 4 cycles -> completion delayed exactly 4 cycles with the correct product.
